localizer_sequencer: RTL and testbench

Frame-level controller for the localizer neighbour-search datapath.
- Collects one sample per sensor into a frame buffer and holds that buffer stable while downstream stages read it.
- Starts the external min-N selection, then launches the nearest-neighbour search with the selected indices and the neighbour-map configuration it owns.
- Returns results through a valid/ready port, with a watchdog so a stalled stage cannot hang the localizer.

---
 rtl/localizer_pkg.sv | 12 +
 rtl/neighbour_map_regfile.sv | 31 +++
 rtl/localizer_sequencer.sv | 143 ++++++++++++++
 tb/tb_localizer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/localizer_pkg.sv
// Shared widths, sentinels, parameter defaults and FSM encoding for the localizer neighbour-search control.
package localizer_pkg;
    localparam int IDX_W = 4;
    localparam logic [15:0] SENTINEL_DATA = 16'hFFFF;
    localparam logic [IDX_W-1:0] SENTINEL_IDX = 4'hF;

    localparam int DEF_DW          = 16;
    localparam int DEF_NUM_SENSORS = 12;
    localparam int DEF_N           = 3;

    typedef enum logic [2:0] {COLLECT, MIN, LAUNCH, RUN, OUT} state_t;
endpackage

// File: rtl/neighbour_map_regfile.sv
// Neighbour-map rows, writable only while the sequencer is idle; rejected writes raise a one-cycle error.
module neighbour_map_regfile
    import localizer_pkg::*;
#(
    parameter int NUM_SENSORS = DEF_NUM_SENSORS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    we,
    input  logic                                    locked,
    input  logic [IDX_W-1:0]                        addr,
    input  logic [NUM_SENSORS-1:0]                  row,
    output logic [NUM_SENSORS-1:0][NUM_SENSORS-1:0] maps,
    output logic                                    err
);
    logic accept;

    assign accept = we && !locked && (addr < IDX_W'(NUM_SENSORS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maps <= '0;
            err  <= 1'b0;
        end else begin
            err <= we && !accept;
            if (accept) begin
                maps[addr] <= row;
            end
        end
    end
endmodule

// File: rtl/localizer_sequencer.sv
// Frame sequencer: collect one sample per sensor, run min-N then neighbour search, return the result.
// The frame buffer, min indices and maps stay frozen from frame completion until the result is taken.
module localizer_sequencer
    import localizer_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int NUM_SENSORS = DEF_NUM_SENSORS,
    parameter int N           = DEF_N,
    parameter int TIMEOUT     = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [DW-1:0]                           s_data,
    input  logic [IDX_W-1:0]                        s_idx,
    input  logic                                    cfg_we,
    input  logic [IDX_W-1:0]                        cfg_addr,
    input  logic [NUM_SENSORS-1:0]                  cfg_map,
    output logic                                    cfg_err,
    output logic                                    busy,
    output logic [NUM_SENSORS-1:0][DW-1:0]          frame_data,
    output logic [NUM_SENSORS-1:0][IDX_W-1:0]       frame_indices,
    output logic                                    mn_start,
    input  logic                                    mn_done,
    input  logic [N-1:0][IDX_W-1:0]                 mn_idx,
    output logic                                    nn_start,
    output logic [N-1:0][IDX_W-1:0]                 nn_min_idx,
    output logic [NUM_SENSORS-1:0][NUM_SENSORS-1:0] nn_maps,
    input  logic                                    nn_done,
    input  logic [N-1:0][DW-1:0]                    nn_data,
    input  logic [N-1:0][IDX_W-1:0]                 nn_idx,
    output logic                                    r_valid,
    input  logic                                    r_ready,
    output logic [N-1:0][DW-1:0]                    r_data,
    output logic [N-1:0][IDX_W-1:0]                 r_idx,
    output logic                                    r_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [NUM_SENSORS-1:0] seen;
    logic [CW-1:0]          wd_cnt;
    logic                   wd_expired;
    logic                   sample_hit;

    assign s_ready    = (state == COLLECT);
    assign busy       = (state != COLLECT);
    assign sample_hit = s_valid && s_ready && (s_idx < IDX_W'(NUM_SENSORS));
    assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            frame_indices[i] = IDX_W'(i);
        end
    end

    neighbour_map_regfile #(.NUM_SENSORS(NUM_SENSORS)) u_maps (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_we),
        .locked (busy),
        .addr   (cfg_addr),
        .row    (cfg_map),
        .maps   (nn_maps),
        .err    (cfg_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            seen       <= '0;
            frame_data <= '0;
            nn_min_idx <= '0;
            wd_cnt     <= '0;
            mn_start   <= 1'b0;
            nn_start   <= 1'b0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_data     <= {N{DW'(SENTINEL_DATA)}};
            r_idx      <= {N{SENTINEL_IDX}};
        end else begin
            mn_start <= 1'b0;
            nn_start <= 1'b0;
            wd_cnt   <= wd_cnt + 1'b1;
            case (state)
                COLLECT: begin
                    wd_cnt <= '0;
                    if (sample_hit) begin
                        frame_data[s_idx] <= s_data;
                        seen[s_idx]       <= 1'b1;
                    end
                    if (&seen) begin
                        state    <= MIN;
                        mn_start <= 1'b1;
                    end
                end
                MIN: begin
                    if (mn_done) begin
                        nn_min_idx <= mn_idx;
                        nn_start   <= 1'b1;
                        state      <= LAUNCH;
                    end else if (wd_expired) begin
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_data    <= {N{DW'(SENTINEL_DATA)}};
                        r_idx     <= {N{SENTINEL_IDX}};
                        state     <= OUT;
                    end
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    // A done landing on the watchdog limit still delivers real data.
                    if (nn_done) begin
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b0;
                        r_data    <= nn_data;
                        r_idx     <= nn_idx;
                        state     <= OUT;
                    end else if (wd_expired) begin
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_data    <= {N{DW'(SENTINEL_DATA)}};
                        r_idx     <= {N{SENTINEL_IDX}};
                        state     <= OUT;
                    end
                end
                OUT: begin
                    wd_cnt <= '0;
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        seen    <= '0;
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_localizer_sequencer.sv
// Randomized frame-level bench for localizer_sequencer against a per-sensor frame/map model.
module tb_localizer_sequencer;
    localparam int DW = 16;
    localparam int NS = 12;
    localparam int N  = 3;
    localparam int TO = 64;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    s_valid, s_ready;
    logic [DW-1:0]           s_data;
    logic [3:0]              s_idx;
    logic                    cfg_we, cfg_err, busy;
    logic [3:0]              cfg_addr;
    logic [NS-1:0]           cfg_map;
    logic [NS-1:0][DW-1:0]   frame_data;
    logic [NS-1:0][3:0]      frame_indices;
    logic                    mn_start, mn_done, nn_start, nn_done;
    logic [N-1:0][3:0]       mn_idx, nn_min_idx, nn_idx, r_idx;
    logic [NS-1:0][NS-1:0]   nn_maps;
    logic [N-1:0][DW-1:0]    nn_data, r_data;
    logic                    r_valid, r_ready, r_timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [3:0] idx; logic [DW-1:0] data; } smp_t;
    smp_t                  plan[$];
    logic [NS-1:0][DW-1:0] exp_frame;
    logic [NS-1:0][NS-1:0] exp_maps;
    logic [N-1:0][3:0]     exp_min;

    localizer_sequencer #(.DW(DW), .NUM_SENSORS(NS), .N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_idx(s_idx),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_map(cfg_map), .cfg_err(cfg_err), .busy(busy),
        .frame_data(frame_data), .frame_indices(frame_indices), .mn_start(mn_start), .mn_done(mn_done),
        .mn_idx(mn_idx), .nn_start(nn_start), .nn_min_idx(nn_min_idx), .nn_maps(nn_maps),
        .nn_done(nn_done), .nn_data(nn_data), .nn_idx(nn_idx), .r_valid(r_valid), .r_ready(r_ready),
        .r_data(r_data), .r_idx(r_idx), .r_timeout(r_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++; if (s_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL %s_ready_busy got %b%b want 10", tag, s_ready, busy); end
        vectors++; if (mn_start !== 1'b0 || nn_start !== 1'b0 || cfg_err !== 1'b0) begin miscompares++; $display("FAIL %s_pulses got %b%b%b want 000", tag, mn_start, nn_start, cfg_err); end
        vectors++; if (r_valid !== 1'b0 || r_timeout !== 1'b0) begin miscompares++; $display("FAIL %s_rvalid got %b%b want 00", tag, r_valid, r_timeout); end
        vectors++; if (r_data !== {N{16'hFFFF}} || r_idx !== {N{4'hF}}) begin miscompares++; $display("FAIL %s_rdata got %h/%h want all-ones", tag, r_data, r_idx); end
        vectors++; if (frame_data !== '0 || nn_maps !== '0 || nn_min_idx !== '0) begin miscompares++; $display("FAIL %s_regs got %h/%h/%h want 0", tag, frame_data, nn_maps, nn_min_idx); end
    endtask

    task automatic test_reset;
        logic [NS-1:0][3:0] fi;
        s_valid = 0; s_idx = 0; s_data = 0; cfg_we = 0; cfg_addr = 0; cfg_map = 0;
        mn_done = 0; mn_idx = 0; nn_done = 0; nn_data = 0; nn_idx = 0; r_ready = 0;
        rst = 1; repeat (2) tick; rst = 0; tick;
        exp_frame = '0; exp_maps = '0; exp_min = '0;
        check_reset_outputs("reset");
        for (int i = 0; i < NS; i++) fi[i] = 4'(i);
        vectors++; if (frame_indices !== fi) begin miscompares++; $display("FAIL frame_indices got %h want %h", frame_indices, fi); end
    endtask

    task automatic build_random_plan(input bit junk);
        bit got[NS];
        int cnt = 0;
        smp_t s;
        plan.delete();
        for (int i = 0; i < NS; i++) got[i] = 0;
        while (cnt < NS) begin
            s.data = 16'($urandom);
            if (junk && plan.size() < 30 && $urandom_range(0, 2) == 0) begin
                s.idx = 4'($urandom_range(0, 15));
            end else begin
                int st = $urandom_range(0, NS - 1);
                s.idx = 4'(st);
                for (int k = 0; k < NS; k++) if (!got[(st + k) % NS]) begin s.idx = 4'((st + k) % NS); break; end
            end
            if (int'(s.idx) < NS && !got[s.idx]) begin got[s.idx] = 1; cnt++; end
            plan.push_back(s);
        end
    endtask

    // Drives the plan; the last entry is the one that completes the frame.
    task automatic feed;
        for (int k = 0; k < plan.size(); k++) begin
            s_valid = 0;
            repeat ($urandom_range(0, 1)) tick;
            s_valid = 1; s_idx = plan[k].idx; s_data = plan[k].data;
            vectors++; if (s_ready !== 1'b1 || mn_start !== 1'b0) begin miscompares++; $display("FAIL feed_ready[%0d] got %b%b want 10", k, s_ready, mn_start); end
            tick;
            if (int'(plan[k].idx) < NS) exp_frame[plan[k].idx] = plan[k].data;
        end
        s_valid = 0;
        vectors++; if (mn_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL feed_early_min got %b%b want 00", mn_start, busy); end
        tick;
        vectors++; if (mn_start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin miscompares++; $display("FAIL feed_mn_start got %b%b%b want 110", mn_start, busy, s_ready); end
        vectors++; if (frame_data !== exp_frame) begin miscompares++; $display("FAIL feed_frame got %h want %h", frame_data, exp_frame); end
        tick;
        vectors++; if (mn_start !== 1'b0) begin miscompares++; $display("FAIL feed_mn_pulse got %b want 0", mn_start); end
    endtask

    task automatic finish_min(input int delay, input logic [N-1:0][3:0] mi);
        nn_done = 1; nn_data = {N{16'h1234}}; nn_idx = '0;
        repeat (delay) tick;
        nn_done = 0;
        mn_done = 1; mn_idx = mi;
        tick;
        mn_done = 0; mn_idx = 12'($urandom);
        exp_min = mi;
        vectors++; if (nn_start !== 1'b1 || nn_min_idx !== exp_min || r_valid !== 1'b0) begin miscompares++; $display("FAIL nn_start got %b/%h/%b want 1/%h/0", nn_start, nn_min_idx, r_valid, exp_min); end
        tick;
        vectors++; if (nn_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL nn_pulse got %b%b want 01", nn_start, busy); end
    endtask

    task automatic finish_run(input int delay, input logic [N-1:0][DW-1:0] d, input logic [N-1:0][3:0] ix);
        repeat (delay) tick;
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL run_early got %b want 0", r_valid); end
        nn_done = 1; nn_data = d; nn_idx = ix;
        tick;
        nn_done = 0; nn_data = {N{16'($urandom)}}; nn_idx = 12'($urandom);
        vectors++; if (r_valid !== 1'b1 || r_timeout !== 1'b0) begin miscompares++; $display("FAIL result_valid got %b%b want 10", r_valid, r_timeout); end
        vectors++; if (r_data !== d || r_idx !== ix) begin miscompares++; $display("FAIL result_data got %h/%h want %h/%h", r_data, r_idx, d, ix); end
        vectors++; if (frame_data !== exp_frame || nn_min_idx !== exp_min || nn_maps !== exp_maps) begin miscompares++; $display("FAIL held_buffers got %h/%h", frame_data, nn_min_idx); end
    endtask

    task automatic release_out(input int hold);
        repeat (hold) tick;
        r_ready = 1;
        vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL out_hold got %b want 1", r_valid); end
        tick;
        r_ready = 0;
        vectors++; if (r_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL out_release got %b%b%b want 010", r_valid, s_ready, busy); end
    endtask

    task automatic test_cfg;
        for (int i = 0; i < NS; i++) begin
            cfg_we = 1; cfg_addr = 4'(i); cfg_map = 12'h003 << i;
            exp_maps[i] = 12'h003 << i;
            tick;
            cfg_we = 0;
            vectors++; if (nn_maps !== exp_maps || cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_row%0d got %h/%b want %h/0", i, nn_maps, cfg_err, exp_maps); end
        end
        cfg_we = 1; cfg_addr = 4'd12; cfg_map = 12'($urandom);
        tick;
        cfg_we = 0;
        vectors++; if (cfg_err !== 1'b1 || nn_maps !== exp_maps) begin miscompares++; $display("FAIL cfg_addr12 got %b/%h want 1/%h", cfg_err, nn_maps, exp_maps); end
        tick;
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_err_pulse got %b want 0", cfg_err); end
        cfg_we = 1; cfg_addr = 4'd11; cfg_map = ~exp_maps[11];
        exp_maps[11] = ~exp_maps[11];
        tick;
        cfg_we = 0;
        vectors++; if (nn_maps !== exp_maps || cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_addr11 got %h/%b want %h/0", nn_maps, cfg_err, exp_maps); end
    endtask

    task automatic test_basic_frame;
        plan.delete();
        for (int i = 0; i < NS; i++) plan.push_back('{4'(i), 16'(100 + i)});
        feed();
        finish_min(0, {4'd7, 4'd5, 4'd2});
        finish_run(3, {16'd9, 16'd4, 16'd3}, {4'd8, 4'd4, 4'd1});
        release_out(0);
    endtask

    task automatic test_duplicate;
        plan.delete();
        plan.push_back('{4'd3, 16'($urandom)});
        plan.push_back('{4'd13, 16'hDEAD});
        plan.push_back('{4'd3, 16'h0055});
        for (int i = 0; i < NS; i++) if (i != 3) plan.push_back('{4'(i), 16'($urandom)});
        feed();
        vectors++; if (frame_data[3] !== 16'h0055) begin miscompares++; $display("FAIL dup_entry3 got %h want 0055", frame_data[3]); end
        finish_min(2, 12'($urandom));
        finish_run(1, {N{16'($urandom)}}, 12'($urandom));
        release_out(1);
    endtask

    task automatic test_timeout;
        bit early = 0;
        build_random_plan(0);
        feed();
        finish_min(5, 12'($urandom));
        for (int c = 1; c < TO; c++) begin
            tick;
            if (r_valid !== 1'b0) early = 1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL run_wd_early got 1 want 0"); end
        tick;
        vectors++; if (r_valid !== 1'b1 || r_timeout !== 1'b1) begin miscompares++; $display("FAIL run_wd got %b%b want 11", r_valid, r_timeout); end
        vectors++; if (r_data !== {N{16'hFFFF}} || r_idx !== {N{4'hF}}) begin miscompares++; $display("FAIL run_wd_data got %h/%h want sentinels", r_data, r_idx); end
    endtask

    task automatic test_hold_out;
        bit bad_stable = 0;
        bit bad_ready = 0;
        s_valid = 1; s_idx = 4'd0; s_data = ~exp_frame[0];
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin cfg_we = 1; cfg_addr = 4'd2; cfg_map = ~exp_maps[2]; end
            tick;
            cfg_we = 0;
            if (c == 5) begin
                vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL busy_cfg_err got %b want 1", cfg_err); end
            end
            if (c == 6) begin
                vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL busy_cfg_pulse got %b want 0", cfg_err); end
            end
            if (r_valid !== 1'b1 || r_timeout !== 1'b1 || r_data !== {N{16'hFFFF}} || r_idx !== {N{4'hF}}) bad_stable = 1;
            if (s_ready !== 1'b0) bad_ready = 1;
        end
        s_valid = 0;
        vectors++; if (bad_stable !== 1'b0 || bad_ready !== 1'b0) begin miscompares++; $display("FAIL out_stable got %b%b want 00", bad_stable, bad_ready); end
        vectors++; if (nn_maps !== exp_maps || frame_data !== exp_frame) begin miscompares++; $display("FAIL out_frozen got %h/%h", nn_maps, frame_data); end
        release_out(0);
    endtask

    task automatic test_done_at_limit;
        logic [N-1:0][DW-1:0] d;
        d = {16'($urandom), 16'($urandom), 16'($urandom)};
        build_random_plan(1);
        feed();
        finish_min(1, 12'($urandom));
        finish_run(TO - 1, d, {4'd0, 4'd6, 4'd11});
        release_out(2);
    endtask

    task automatic test_min_timeout;
        bit early = 0;
        build_random_plan(1);
        feed();
        for (int c = 2; c < TO; c++) begin
            tick;
            if (r_valid !== 1'b0) early = 1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL min_wd_early got 1 want 0"); end
        tick;
        vectors++; if (r_valid !== 1'b1 || r_timeout !== 1'b1 || r_idx !== {N{4'hF}}) begin miscompares++; $display("FAIL min_wd got %b%b/%h want 11/fff", r_valid, r_timeout, r_idx); end
        vectors++; if (nn_min_idx !== exp_min) begin miscompares++; $display("FAIL min_wd_idx got %h want %h", nn_min_idx, exp_min); end
        release_out(0);
    endtask

    task automatic test_reset_mid;
        build_random_plan(0);
        feed();
        finish_min(0, 12'($urandom));
        tick;
        #3 rst = 1;
        #1;
        exp_frame = '0; exp_maps = '0; exp_min = '0;
        check_reset_outputs("mid_reset");
        #1 rst = 0;
        tick;
        build_random_plan(1);
        feed();
        finish_min(3, 12'($urandom));
        finish_run(4, {N{16'($urandom)}}, 12'($urandom));
        release_out(0);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 6; f++) begin
            logic [3:0] a;
            logic [NS-1:0] m;
            a = 4'($urandom_range(0, 15)); m = 12'($urandom);
            cfg_we = 1; cfg_addr = a; cfg_map = m;
            tick;
            cfg_we = 0;
            if (int'(a) < NS) exp_maps[a] = m;
            vectors++; if (cfg_err !== (int'(a) >= NS) || nn_maps !== exp_maps) begin miscompares++; $display("FAIL b2b_cfg%0d got %b/%h want %h", f, cfg_err, nn_maps, exp_maps); end
            mn_done = 1; mn_idx = 12'($urandom);
            tick;
            mn_done = 0;
            vectors++; if (nn_min_idx !== exp_min || busy !== 1'b0 || nn_start !== 1'b0) begin miscompares++; $display("FAIL b2b_stray_done%0d got %h/%b", f, nn_min_idx, busy); end
            build_random_plan(1);
            feed();
            finish_min($urandom_range(0, 5), 12'($urandom));
            finish_run($urandom_range(0, 8), {16'($urandom), 16'($urandom), 16'($urandom)}, 12'($urandom));
            release_out($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_basic_frame();
        test_duplicate();
        test_timeout();
        test_hold_out();
        test_done_at_limit();
        test_min_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
